lsu_mem_stage: RTL

Load/store unit directly downstream of the ALU. It takes the ALU result as the effective address, plus the store data and the width/sign code from the decoder. It runs one data-memory transaction over a req/gnt/rvalid bus and returns sign- or zero-extended load data for write-back. While a transaction is in flight it raises a stall so the single-cycle datapath holds the PC.

---
 rtl/lsu_mem_stage_if.sv | 23 ++
 rtl/lsu_mem_stage.sv | 117 +++++++++++
 2 files changed

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: req/gnt/rvalid data-memory bus between the LSU (master) and memory (slave)
interface lsu_mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: single-transaction load/store unit on a req/gnt/rvalid bus; define LSU_TIMEOUT_EN for the watchdog
module lsu_mem_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    lsu_mem_stage_if.master   mem,
    output logic [31:0]       ld_data,
    output logic              done,
    output logic              stall,
    output logic              err,
    output logic [1:0]        err_code
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t      state, state_n;
    logic        illegal, misaligned, accept, timeout;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [3:0]  be_n;
    logic [31:0] wd_n, ld_n;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign illegal    = funct3 == 3'b011 || funct3[2:1] == 2'b11 || (is_store && funct3[2]);
    assign misaligned = funct3[1:0] == 2'b01 ? addr[0] : funct3[1:0] == 2'b10 ? |addr[1:0] : 1'b0;
    assign accept     = start && state == IDLE && !illegal && !misaligned;
    assign stall      = state != IDLE || accept;
    assign mem.mem_req = state == REQ;

    assign be_n = funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                  funct3[1:0] == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd_n = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                  funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;

    // lane extraction uses the offset captured at issue, not the live address
    assign ld_b = 8'(mem.mem_rdata >> {off_q, 3'b000});
    assign ld_h = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    assign ld_n = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & ld_b[7]}}, ld_b} :
                  f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & ld_h[15]}}, ld_h} : mem.mem_rdata;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= state == IDLE ? '0 : cnt + CW'(1);
    end

    assign timeout = state != IDLE && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = timeout ? IDLE :
                  state == IDLE ? (accept ? REQ : IDLE) :
                  state == REQ ? (mem.mem_gnt ? (mem.mem_we ? IDLE : WAIT_R) : REQ) :
                  (mem.mem_rvalid ? IDLE : WAIT_R);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
            f3_q          <= '0;
            off_q         <= '0;
            ld_data       <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= 2'b00;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            if (start && state == IDLE && (illegal || misaligned)) begin
                err      <= 1'b1;
                err_code <= illegal ? 2'b10 : 2'b01;
            end
            if (accept) begin
                mem.mem_we    <= is_store;
                mem.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                mem.mem_be    <= be_n;
                mem.mem_wdata <= wd_n;
                f3_q          <= funct3;
                off_q         <= addr[1:0];
            end
            if (timeout) begin
                err      <= 1'b1;
                err_code <= 2'b11;
            end else if (state == REQ && mem.mem_gnt && mem.mem_we) begin
                done <= 1'b1;
            end else if (state == WAIT_R && mem.mem_rvalid) begin
                done    <= 1'b1;
                ld_data <= ld_n;
            end
        end
    end
endmodule
